// File: rtl/sort_engine_p.sv
// In-place bubble-sort engine with early exit over a 2^L x N register RAM.
// Host loads/reads the RAM directly; a start edge sorts a prefix of runtime length.
module sort_engine_p #(
    parameter int N      = 8,
    parameter int L      = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           WrInit,
    input  logic           Rd,
    input  logic [L-1:0]   RAddr,
    input  logic [N-1:0]   DataIn,
    input  logic [L:0]     Len,
    input  logic           descend,
    input  logic           start,
    output logic [N-1:0]   DataOut,
    output logic           busy,
    output logic           done,
    output logic [2*L-1:0] swaps
);
    localparam int DEPTH = 1 << L;
    localparam logic [L:0] DEPTH_W = {1'b1, {L{1'b0}}};

    typedef enum logic [1:0] {IDLE, CMP, PEND, DONE} state_t;

    state_t         state, state_n;
    logic [N-1:0]   mem [DEPTH];
    logic [L-1:0]   j, j_n, j1, lim, lim_n;
    logic           swapped, swapped_n, desc_q, desc_n, start_q;
    logic           busy_n, done_n;
    logic [2*L-1:0] swaps_n;
    logic [N-1:0]   a, b;
    logic [L:0]     len_c;
    logic           gt, lt, do_swap, launch, wr_ok, idle_like;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign launch    = start && !start_q && idle_like;
    assign wr_ok     = WrInit && idle_like;
    assign len_c     = (Len > DEPTH_W) ? DEPTH_W : Len;

    assign j1 = j + 1'b1;
    assign a  = mem[j];
    assign b  = mem[j1];
    assign gt = SIGNED ? ($signed(a) > $signed(b)) : (a > b);
    assign lt = SIGNED ? ($signed(a) < $signed(b)) : (a < b);
    // Strict compares keep equal words in place, so the sort is stable.
    assign do_swap = (state == CMP) && (desc_q ? lt : gt);

    always_comb begin
        state_n   = state;
        j_n       = j;
        lim_n     = lim;
        swapped_n = swapped;
        desc_n    = desc_q;
        busy_n    = busy;
        done_n    = done;
        swaps_n   = swaps;
        if (wr_ok) done_n = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (launch) begin
                    desc_n    = descend;
                    j_n       = '0;
                    swapped_n = 1'b0;
                    swaps_n   = '0;
                    lim_n     = L'(len_c - 1'b1);
                    if (len_c[L:1] == '0) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = CMP;
                        busy_n  = 1'b1;
                        done_n  = 1'b0;
                    end
                end
            end
            CMP: begin
                if (do_swap) begin
                    swapped_n = 1'b1;
                    if (swaps != '1) swaps_n = swaps + 1'b1;
                end
                if (j == lim - 1'b1) state_n = PEND;
                else                 j_n = j1;
            end
            PEND: begin
                if (!swapped || lim == 1) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    lim_n     = lim - 1'b1;
                    j_n       = '0;
                    swapped_n = 1'b0;
                    state_n   = CMP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            swaps   <= '0;
            DataOut <= '0;
            j       <= '0;
            lim     <= '0;
            swapped <= 1'b0;
            desc_q  <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= start;
            busy    <= busy_n;
            done    <= done_n;
            swaps   <= swaps_n;
            j       <= j_n;
            lim     <= lim_n;
            swapped <= swapped_n;
            desc_q  <= desc_n;
            if (Rd) DataOut <= mem[RAddr];
        end
    end

    // RAM is never cleared; a reset edge only suppresses the pending swap/write.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (do_swap) begin
                mem[j]  <= b;
                mem[j1] <= a;
            end else if (wr_ok) begin
                mem[RAddr] <= DataIn;
            end
        end
    end
endmodule

// File: tb/tb_sort_engine_p.sv
// Self-checking bench for sort_engine_p: unsigned and signed instances share stimulus,
// an array-level sort model supplies per-cycle expectations.
module tb_sort_engine_p;
    typedef logic [7:0] arr_t [16];

    logic       clk = 1'b0, rst = 1'b0, WrInit = 1'b0, Rd = 1'b0, descend = 1'b0, start = 1'b0;
    logic [3:0] RAddr = '0;
    logic [7:0] DataIn = '0;
    logic [4:0] Len = '0;
    logic [7:0] DataOut, s_DataOut, swaps, s_swaps;
    logic       busy, done, s_busy, s_done;

    int   total = 0, passed = 0;
    bit   chk_en = 1'b0;
    arr_t mdl, smdl;
    bit   exp_busy, exp_done, exp_sbusy, exp_sdone, swaps_v, sswaps_v, dout_v;
    int   exp_swaps, exp_sswaps;
    logic [7:0] exp_dout, exp_sdout;
    int   last_cu, last_sw, last_cs, last_ssw;

    sort_engine_p #(.N(8), .L(4), .SIGNED(1'b0)) dut (
        .clk(clk), .rst(rst), .WrInit(WrInit), .Rd(Rd), .RAddr(RAddr), .DataIn(DataIn),
        .Len(Len), .descend(descend), .start(start), .DataOut(DataOut), .busy(busy),
        .done(done), .swaps(swaps));

    sort_engine_p #(.N(8), .L(4), .SIGNED(1'b1)) u_s (
        .clk(clk), .rst(rst), .WrInit(WrInit), .Rd(Rd), .RAddr(RAddr), .DataIn(DataIn),
        .Len(Len), .descend(descend), .start(start), .DataOut(s_DataOut), .busy(s_busy),
        .done(s_done), .swaps(s_swaps));

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(exp_busy));
            check("done", int'(done), int'(exp_done));
            check("s_busy", int'(s_busy), int'(exp_sbusy));
            check("s_done", int'(s_done), int'(exp_sdone));
            if (swaps_v)  check("swaps", int'(swaps), exp_swaps);
            if (sswaps_v) check("s_swaps", int'(s_swaps), exp_sswaps);
            if (dout_v) begin
                check("DataOut", int'(DataOut), int'(exp_dout));
                check("s_DataOut", int'(s_DataOut), int'(exp_sdout));
            end
        end
    end

    function automatic bit ooo(logic [7:0] a, logic [7:0] b, bit desc, bit sgn);
        int x, y;
        x = sgn ? int'($signed(a)) : int'(a);
        y = sgn ? int'($signed(b)) : int'(b);
        return desc ? (x < y) : (x > y);
    endfunction

    // Bubble sort with early exit; each compare and each end-of-pass costs one cycle.
    // Stops after rlim cycles to model an interrupting reset (cyc then stays huge).
    task automatic model_sort(input arr_t mi, input int len, input bit desc, input bit sgn,
                              input int rlim, output arr_t mo, output int cyc, output int sw);
        int n, lim, c;
        bit swp;
        logic [7:0] t;
        mo = mi; c = 0; sw = 0; cyc = 1000000;
        n = (len > 16) ? 16 : len;
        if (n <= 1) begin cyc = 0; return; end
        lim = n - 1;
        forever begin
            swp = 1'b0;
            for (int i = 0; i < lim; i++) begin
                c++;
                if (c > rlim) return;
                if (ooo(mo[i], mo[i+1], desc, sgn)) begin
                    t = mo[i]; mo[i] = mo[i+1]; mo[i+1] = t;
                    swp = 1'b1; sw++;
                end
            end
            c++;
            if (c > rlim) return;
            if (!swp || lim == 1) begin cyc = c; return; end
            lim--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_exp();
        exp_busy = 0; exp_done = 0; exp_sbusy = 0; exp_sdone = 0;
        swaps_v = 1; sswaps_v = 1; exp_swaps = 0; exp_sswaps = 0;
        dout_v = 1; exp_dout = '0; exp_sdout = '0;
    endtask

    task automatic wr(input int addr, input int data);
        WrInit = 1'b1; RAddr = 4'(addr); DataIn = 8'(data);
        step();
        WrInit = 1'b0;
        mdl[addr] = 8'(data); smdl[addr] = 8'(data);
        exp_done = 0; exp_sdone = 0;
    endtask

    task automatic rd(input int addr);
        Rd = 1'b1; RAddr = 4'(addr);
        step();
        Rd = 1'b0;
        exp_dout = mdl[addr]; exp_sdout = smdl[addr];
    endtask

    task automatic rd_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) rd(i);
    endtask

    task automatic run_sort(input int len, input bit desc, input bit hold, input int extra,
                            input int rst_at, input int wr_at, input int wa, input int wd);
        arr_t nu, ns;
        int cu, sw, cs, ssw, k, maxc, rl;
        rl = (rst_at >= 0) ? rst_at : 1000000;
        model_sort(mdl, len, desc, 1'b0, rl, nu, cu, sw);
        model_sort(smdl, len, desc, 1'b1, rl, ns, cs, ssw);
        last_cu = cu; last_sw = sw; last_cs = cs; last_ssw = ssw;
        mdl = nu; smdl = ns;
        Len = 5'(len); descend = desc; start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        k = 0;
        maxc = ((cu > cs) ? cu : cs) + extra;
        forever begin
            exp_busy  = (k < cu); exp_done  = (k >= cu);
            exp_sbusy = (k < cs); exp_sdone = (k >= cs);
            swaps_v   = (k == 0) || (k >= cu); exp_swaps  = (k >= cu) ? sw : 0;
            sswaps_v  = (k == 0) || (k >= cs); exp_sswaps = (k >= cs) ? ssw : 0;
            if (k >= maxc) break;
            if (k == wr_at) begin WrInit = 1'b1; RAddr = 4'(wa); DataIn = 8'(wd); end
            if (k == rst_at) rst = 1'b0;
            step();
            k++;
            WrInit = 1'b0;
            if (rst_at >= 0 && k == rst_at + 1) begin
                rst = 1'b1;
                reset_exp();
                break;
            end
        end
        start = 1'b0;
    endtask

    arr_t init_v, asc_exp, rev_v;

    initial begin
        init_v  = '{45, 12, 78, 34, 56, 89, 23, 67, 201, 17, 140, 99, 250, 3, 128, 64};
        asc_exp = '{12, 23, 34, 45, 56, 67, 78, 89, 201, 17, 140, 99, 250, 3, 128, 64};
        rev_v   = '{80, 70, 60, 50, 40, 30, 20, 10, 0, 0, 0, 0, 0, 0, 0, 0};
        mdl = init_v; smdl = init_v;

        rst = 1'b0;
        step(); step();
        reset_exp();
        chk_en = 1'b1;
        rst = 1'b1;
        step();

        for (int i = 0; i < 16; i++) wr(i, int'(init_v[i]));
        rd_range(0, 7);

        run_sort(8, 1'b0, 1'b0, 1, -1, -1, 0, 0);
        check("asc_cycles", last_cu, 33);
        check("asc_swaps", last_sw, 11);
        for (int i = 0; i < 16; i++) check("asc_model", int'(mdl[i]), int'(asc_exp[i]));
        rd_range(0, 15);

        for (int i = 0; i < 8; i++) wr(i, int'(init_v[i]));
        run_sort(8, 1'b1, 1'b0, 1, -1, -1, 0, 0);
        check("desc_swaps", last_sw, 17);
        check("desc_first", int'(mdl[0]), 89);
        check("desc_last", int'(mdl[7]), 12);
        rd_range(0, 7);

        run_sort(8, 1'b1, 1'b0, 1, -1, -1, 0, 0);
        check("presorted_cycles", last_cu, 8);
        check("presorted_swaps", last_sw, 0);

        // reversed input; write during busy must be dropped; start held past done
        run_sort(8, 1'b0, 1'b1, 5, -1, 3, 2, 0);
        check("rev_cycles", last_cu, 35);
        check("rev_swaps", last_sw, 28);
        rd_range(0, 7);
        check("busy_write_dropped", int'(mdl[2]), 34);

        wr(8, 77);
        step();

        run_sort(1, 1'b0, 1'b0, 1, -1, -1, 0, 0);
        check("len1_cycles", last_cu, 0);
        rd_range(0, 1);

        wr(0, 'h7F); wr(1, 'h80); wr(2, 'h00); wr(3, 'hFF);
        run_sort(4, 1'b0, 1'b0, 1, -1, -1, 0, 0);
        check("signed0", int'(smdl[0]), 'h80);
        check("signed1", int'(smdl[1]), 'hFF);
        check("signed2", int'(smdl[2]), 'h00);
        check("signed3", int'(smdl[3]), 'h7F);
        check("unsigned0", int'(mdl[0]), 'h00);
        check("unsigned3", int'(mdl[3]), 'hFF);
        rd_range(0, 3);

        run_sort(20, 1'b0, 1'b0, 1, -1, -1, 0, 0);
        for (int i = 0; i < 15; i++) check("len20_order", int'(mdl[i] <= mdl[i+1]), 1);
        rd_range(0, 15);

        for (int i = 0; i < 8; i++) wr(i, int'(rev_v[i]));
        run_sort(8, 1'b0, 1'b0, 1, 10, -1, 0, 0);
        step();
        rd_range(0, 7);
        run_sort(8, 1'b0, 1'b0, 1, -1, -1, 0, 0);
        check("after_reset_first", int'(mdl[0]), 10);
        check("after_reset_last", int'(mdl[7]), 80);
        rd_range(0, 7);

        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sort_engine_p.md
Name: sort_engine_p

Overview:
- Parametrised, in-place bubble-sort engine with early exit, the next generation of the team's fixed 8-entry sorting_top.
- Holds a 2^L-entry, N-bit register-array RAM. The host loads it through a write port, starts a sort over a runtime-selected prefix length in ascending or descending order, and then reads the results back.
- Also reports a busy flag and a swap count for performance monitoring.

Parameters:
N, 8, data word width in bits
L, 4, address width; RAM depth is 2^L words
SIGNED, 0, 1 = compare words as two's complement; 0 = unsigned

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
WrInit  in  1  host write strobe
Rd  in  1  host read strobe
RAddr  in  L  host read/write address
DataIn  in  N  host write data
Len  in  L+1  number of elements to sort (elements 0..Len-1); sampled at launch
descend  in  1  0 = ascending, 1 = descending; sampled at launch
start  in  1  level input; sort launches on its 0->1 transition
DataOut  out  N  registered read data
busy  out  1  sort in progress
done  out  1  sort complete (sticky)
swaps  out  2L  number of swaps performed by the last or current sort

Behaviour:
- Single clock domain. Reset is synchronous, active-low, named rst.
- Reset values:
  - DataOut=0, busy=0, done=0, swaps=0.
  - FSM goes to IDLE; start edge register start_q=0.
  - RAM contents are not reset.
- Reset mid-sort: abort immediately to IDLE. RAM keeps its partially sorted contents.
- start held high across reset release counts as a 0->1 edge: one sort launches in the first cycle after reset.
- Host write: in IDLE or DONE, WrInit=1 writes mem[RAddr]<=DataIn at the edge and clears done. While busy, WrInit is ignored.
- Host read: Rd=1 loads DataOut<=mem[RAddr] at the edge, so data is visible one cycle later. Rd=0 holds DataOut. Rd is legal in any state, including busy (returns live contents).
- Launch: in IDLE or DONE, with start=1 and start_q=0, at the edge:
  - Latch Len, clamped to 2^L if larger, and latch descend.
  - Set j=0, lim=Len-1, swapped=0, swaps=0.
  - Set busy=1, done=0; go to CMP.
  - If Len<=1, go to DONE instead: busy stays 0, done=1, swaps=0.
- Out-of-order test:
  - Ascending: out-of-order when mem[j] > mem[j+1].
  - Descending: out-of-order when mem[j] < mem[j+1].
  - Compare strictly, so equal words never swap (sort is stable). Signedness follows SIGNED.
- States:
  - IDLE: wait for launch.
  - CMP: one compare per cycle. If out of order, swap mem[j] and mem[j+1] in the same edge, set swapped=1 and swaps+=1. If j==lim-1 go to PEND, else j+=1.
  - PEND (one cycle): if swapped==0 or lim==1, go to DONE with busy=0, done=1. Otherwise lim-=1, j=0, swapped=0, go to CMP.
  - DONE: done held high until the next launch or an accepted WrInit. A start edge relaunches directly.
- Start edges while busy are ignored. start_q tracks start every cycle.
- Latency:
  - Each pass with k compares takes k+1 cycles.
  - Presorted Len=8: 8 cycles from launch edge to the done edge.
  - Fully reversed Len=8: 35 cycles.
- swaps saturates at 2^(2L)-1; this is unreachable for legal Len.

Test Plan:
- Reset and readback: rst=0 for 2 cycles → all outputs 0. Write 45,12,78,34,56,89,23,67 to addresses 0-7, then Rd each address → DataOut matches one cycle after each read.
- Ascending sort: Len=8, descend=0, start 0->1 → busy for 33 cycles, then done=1, swaps=11. Readback gives 12,23,34,45,56,67,78,89. Addresses 8-15 are unchanged.
- Descending and edge cases:
  - Same load, descend=1 → 89,78,67,56,45,34,23,12 and swaps=17.
  - Presorted input → done after 8 cycles, swaps=0.
- Signed and boundary lengths:
  - SIGNED=1, load 0x7F,0x80,0x00,0xFF, Len=4, ascending → 0x80,0xFF,0x00,0x7F.
  - Len=1 → done next cycle, RAM unchanged.
  - Len=20 with L=4 → whole 16-entry RAM sorted.
- Protocol:
  - WrInit during busy → RAM write suppressed.
  - start held high after done → no relaunch.
  - WrInit after done → done clears.
- Reset mid-sort: rst=0 at cycle 10 of reversed sort → busy=0, done=0 next edge. Later readback shows partial order; a fresh launch completes correctly.
